// File: rtl/fft_peak_tracker_if.sv
// Magnitude stream from the FFT magnitude stage: one bin per valid beat, no backpressure.
interface fft_peak_tracker_if;
    logic [23:0] mag_tdata;
    logic [13:0] mag_tuser;
    logic        mag_tlast;
    logic        mag_tvalid;

    modport master (output mag_tdata, output mag_tuser, output mag_tlast, output mag_tvalid);
    modport slave  (input  mag_tdata, input  mag_tuser, input  mag_tlast, input  mag_tvalid);
endinterface

// File: rtl/fft_peak_tracker.sv
// Per-frame strongest-bin search over an FFT magnitude stream, plus a lock tracker that
// declares a stable note once enough consecutive above-threshold frames agree on the bin.
module fft_peak_tracker #(
    parameter int MIN_BIN       = 1,
    parameter int MAX_BIN       = 1023,
    parameter int STABLE_FRAMES = 4,
    parameter int TOL           = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    fft_peak_tracker_if.slave   mag,
    input  logic [23:0]         threshold,
    output logic [11:0]         peak_bin,
    output logic [23:0]         peak_mag,
    output logic                peak_valid,
    output logic [11:0]         note_bin,
    output logic                note_locked,
    output logic                frame_err
);

    localparam int                CNT_W      = $clog2(STABLE_FRAMES + 1);
    localparam logic [CNT_W-1:0]  STABLE_CNT = CNT_W'(STABLE_FRAMES);
    localparam logic [11:0]       MIN_IDX    = 12'(MIN_BIN);
    localparam logic [11:0]       MAX_IDX    = 12'(MAX_BIN);
    localparam logic [12:0]       TOL_U      = 13'(TOL);

    typedef enum logic {SCAN, REPORT} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= STABLE_CNT) ? STABLE_CNT : c + CNT_W'(1);
    endfunction

    function automatic logic [12:0] abs13(input logic signed [12:0] v);
        return v[12] ? $unsigned(-v) : $unsigned(v);
    endfunction

    state_t            state_q, state_d;
    logic              in_frame_q, in_frame_d;
    logic [13:0]       prev_idx_q, prev_idx_d;
    logic [23:0]       max_mag_q, max_mag_d;
    logic [11:0]       max_bin_q, max_bin_d;
    logic [11:0]       peak_bin_q, peak_bin_d;
    logic [23:0]       peak_mag_q, peak_mag_d;
    logic              frame_err_q, frame_err_d;
    logic [11:0]       cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [11:0]       note_bin_q, note_bin_d;
    logic              note_locked_q, note_locked_d;

    logic [11:0]        idx;
    logic               eligible, seq_err, take, end_frame;
    logic [23:0]        base_mag, cur_mag;
    logic [11:0]        base_bin, cur_bin;
    logic signed [12:0] diff;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= SCAN;
            in_frame_q    <= 1'b0;
            prev_idx_q    <= '0;
            max_mag_q     <= '0;
            max_bin_q     <= '0;
            peak_bin_q    <= '0;
            peak_mag_q    <= '0;
            frame_err_q   <= 1'b0;
            cand_q        <= '0;
            cnt_q         <= '0;
            note_bin_q    <= '0;
            note_locked_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_frame_q    <= in_frame_d;
            prev_idx_q    <= prev_idx_d;
            max_mag_q     <= max_mag_d;
            max_bin_q     <= max_bin_d;
            peak_bin_q    <= peak_bin_d;
            peak_mag_q    <= peak_mag_d;
            frame_err_q   <= frame_err_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            note_bin_q    <= note_bin_d;
            note_locked_q <= note_locked_d;
        end
    end

    // A beat landing in REPORT is processed like any other, so REPORT only
    // repeats when that beat is itself a single-beat frame's tlast.
    always_comb begin
        state_d = SCAN;
        case (state_q)
            SCAN:    state_d = end_frame ? REPORT : SCAN;
            REPORT:  state_d = end_frame ? REPORT : SCAN;
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        peak_valid = (state_q == REPORT);
    end

    always_comb begin
        idx       = mag.mag_tuser[11:0];
        end_frame = mag.mag_tvalid && mag.mag_tlast;
        eligible  = mag.mag_tvalid && (mag.mag_tuser[13:12] == 2'b00)
                    && (idx >= MIN_IDX) && (idx <= MAX_IDX);
        seq_err   = mag.mag_tvalid && in_frame_q && !mag.mag_tlast
                    && (mag.mag_tuser <= prev_idx_q);
        // A first beat or a resynchronising beat compares against a fresh max.
        base_mag  = (!in_frame_q || seq_err) ? 24'd0 : max_mag_q;
        base_bin  = (!in_frame_q || seq_err) ? 12'd0 : max_bin_q;
        // Strict compare on ascending bins keeps the lower bin on a tie.
        take      = eligible && (mag.mag_tdata > base_mag);
        cur_mag   = take ? mag.mag_tdata : base_mag;
        cur_bin   = take ? idx : base_bin;
        diff      = $signed({1'b0, cur_bin}) - $signed({1'b0, cand_q});
    end

    always_comb begin
        in_frame_d    = in_frame_q;
        prev_idx_d    = prev_idx_q;
        max_mag_d     = max_mag_q;
        max_bin_d     = max_bin_q;
        peak_bin_d    = peak_bin_q;
        peak_mag_d    = peak_mag_q;
        frame_err_d   = seq_err;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        note_bin_d    = note_bin_q;
        note_locked_d = note_locked_q;
        if (mag.mag_tvalid) begin
            prev_idx_d = mag.mag_tuser;
            if (end_frame) begin
                in_frame_d = 1'b0;
                max_mag_d  = '0;
                max_bin_d  = '0;
                peak_bin_d = cur_bin;
                peak_mag_d = cur_mag;
                if (cur_mag < threshold) begin
                    cnt_d         = '0;
                    note_locked_d = 1'b0;
                end else begin
                    if (abs13(diff) <= TOL_U) begin
                        cnt_d = sat_inc(cnt_q);
                    end else begin
                        cand_d = cur_bin;
                        cnt_d  = CNT_W'(1);
                    end
                    note_locked_d = (cnt_d == STABLE_CNT);
                    if (cnt_d == STABLE_CNT) begin
                        note_bin_d = cur_bin;
                    end
                end
            end else begin
                in_frame_d = 1'b1;
                max_mag_d  = cur_mag;
                max_bin_d  = cur_bin;
            end
        end
    end

    assign peak_bin    = peak_bin_q;
    assign peak_mag    = peak_mag_q;
    assign note_bin    = note_bin_q;
    assign note_locked = note_locked_q;
    assign frame_err   = frame_err_q;

endmodule

// File: doc/fft_peak_tracker.md
FFT_PEAK_TRACKER -- requirements
Module: fft_peak_tracker

Interface
REQ-001 Parameter MIN_BIN, default 1, lowest bin index searched; bin 0 (DC) is excluded by default.
REQ-002 Parameter MAX_BIN, default 1023, highest bin index searched.
REQ-003 Parameter STABLE_FRAMES, default 4, consecutive agreeing frames required before lock.
REQ-004 Parameter TOL, default 1, max bin distance that counts as agreeing.
REQ-005 clk  in  1  single clock, the 104 MHz FFT-domain clock.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 mag_tdata  in  24  bin magnitude from the FFT magnitude stage.
REQ-008 mag_tuser  in  14  bin index; bits [13:12] nonzero means out of range.
REQ-009 mag_tlast  in  1  last bin of frame.
REQ-010 mag_tvalid  in  1  beat valid; no backpressure, every valid beat is consumed.
REQ-011 threshold  in  24  minimum magnitude for a peak to count; sampled on the tlast beat.
REQ-012 peak_bin  out  12  strongest bin of the last completed frame.
REQ-013 peak_mag  out  24  magnitude of peak_bin.
REQ-014 peak_valid  out  1  one-cycle pulse, peak_bin/peak_mag updated.
REQ-015 note_bin  out  12  locked bin.
REQ-016 note_locked  out  1  level, note_bin is valid.
REQ-017 frame_err  out  1  one-cycle pulse, malformed frame discarded.

Function
REQ-018 The states SHALL be SCAN (accumulating beats) and REPORT (one cycle, publishing the result); REPORT always returns to SCAN.
REQ-019 A valid beat SHALL be eligible only when mag_tuser[13:12]==0 and MIN_BIN <= mag_tuser[11:0] <= MAX_BIN.
REQ-020 An eligible beat SHALL replace the running max only when mag_tdata > running max; on a tie the lower bin wins.
REQ-021 Running max SHALL start each frame at bin 0, magnitude 0.
REQ-022 A valid beat with mag_tlast SHALL be included in the compare; the next cycle SHALL be REPORT, with peak_valid=1 and peak_bin/peak_mag holding the final max.
REQ-023 Latency SHALL be exactly 1 cycle from the tlast beat to peak_valid.
REQ-024 A valid beat arriving during REPORT SHALL be the first beat of the next frame; no beat is ever dropped.
REQ-025 If a valid non-tlast beat has index <= the previous valid beat's index in the same frame (missing tlast), the block SHALL pulse frame_err the next cycle, SHALL NOT pulse peak_valid, SHALL discard the running max, and SHALL treat that beat as the first beat of a new frame.
REQ-026 A frame whose max < threshold SHALL still pulse peak_valid, SHALL clear the agree counter to 0 and note_locked to 0, and SHALL leave note_bin unchanged.
REQ-027 A frame whose max >= threshold SHALL be compared with the candidate bin: if |peak_bin - candidate| <= TOL, the counter increments (saturating at STABLE_FRAMES); otherwise candidate = peak_bin and counter = 1.
REQ-028 When the counter reaches STABLE_FRAMES, note_locked SHALL be 1 and note_bin SHALL equal the current peak_bin, both updated in the REPORT cycle; the lock is held while agreement continues.
REQ-029 The distance SHALL be computed as a 13-bit signed difference with no wrap between bins 0 and 4095.
REQ-030 frame_err frames SHALL NOT change the counter, candidate, or lock.

Reset
REQ-031 When reset_n=0 on a clk edge, state = SCAN, the running max, candidate, and counter = 0, and all outputs = 0.
REQ-032 Reset mid-frame SHALL abandon the partial frame; the first valid beat after reset starts a new frame.

Verification
REQ-033 Frame of bins 0..1023, all magnitude 10 except bin 200 = 5000, threshold 100 -> peak_valid 1 cycle after tlast, peak_bin=200, peak_mag=5000.
REQ-034 Bin 0 = 90000, bins 300 and 301 = 7000, MIN_BIN=1 -> peak_bin=300 (DC excluded, tie goes to the lower bin).
REQ-035 Four frames peaking at bins 200, 201, 200, 199 -> note_locked rises on the 4th peak_valid with note_bin=199; a 5th frame peaking at bin 400 -> note_locked=0, candidate=400, counter=1.
REQ-036 Frame with max 50 and threshold 100 -> peak_valid=1, peak_mag=50, note_locked cleared.
REQ-037 tlast dropped on bin 1023 and the next beat is bin 0 -> frame_err pulses once, no peak_valid, and the following well-formed frame reports correctly.
REQ-038 Back-to-back frames with a valid beat in the REPORT cycle, then reset_n low mid-frame -> both frames reported with no lost beat; after reset all outputs = 0.
